chip8_mem_ctrl: RTL
===================

CHIP8_MEM_CTRL -- requirements
Module: chip8_mem_ctrl

Interface
REQ-001 Parameter: BRAM_LATENCY, default 2, read latency of the external program/data BRAM in cycles.
REQ-002 Ports, in order:
  clk_in  in  1  single clock.
  rst_n_in  in  1  asynchronous, active-low reset.
  timer_decr_in  in  1  60 Hz strobe, one cycle wide.
  mem_addr_in  in  12  processor request address.
  mem_we_in  in  1  processor write enable.
  mem_valid_in  in  1  processor request strobe.
  mem_data_in  in  8  processor write data.
  mem_type_in  in  $clog2(PROC_MEM_TYPE_COUNT)  REG or RAM select.
  mem_ready_out  out  1  processor request may be accepted this cycle.
  mem_valid_out  out  1  processor read data valid, one cycle wide.
  mem_data_out  out  8  processor read data.
  disp_valid_in  in  1  display/sprite read request, RAM only.
  disp_addr_in  in  12  display read address.
  disp_valid_out  out  1  display read data valid.
  disp_data_out  out  8  display read data.
  bram_addr_out  out  12  BRAM address.
  bram_we_out  out  1  BRAM write enable.
  bram_data_out  out  8  BRAM write data.
  bram_data_in  in  8  BRAM read data.
  active_audio_out  out  1  sound timer nonzero.
  error_out  out  1  sticky bad-register-address flag.
REQ-003 The clock is clk_in; reset is rst_n_in, asynchronous and active-low.

Function
REQ-004 Register file SHALL be 32 x 8 flops: 0-15 V0-VF, 16 Ih, 17 Il, 18 PCh, 19 PCl, 20 SP, 21 DT, 22 ST, 23-31 spare.
REQ-005 A request SHALL be accepted on any cycle where mem_valid_in and mem_ready_out are both high; at most one request is accepted per cycle.
REQ-006 mem_ready_out SHALL be the inverse of disp_valid_in, so the display port has fixed priority.
REQ-007 A display request SHALL always be accepted.
REQ-008 Every read, REG or RAM, SHALL return data exactly BRAM_LATENCY+1 cycles after acceptance; responses therefore return in acceptance order.
REQ-009 Read tracking SHALL use a BRAM_LATENCY+1-deep shift pipeline tagged {valid, port, type, reg data}.
REQ-010 RAM access: bram_addr_out, bram_we_out and bram_data_out SHALL be registered, driven the cycle after acceptance.
REQ-011 bram_we_out SHALL be high for exactly one cycle per accepted RAM write.
REQ-012 REG read: the register value SHALL be captured at the acceptance edge and carried through the pipeline.
REQ-013 REG write: the register SHALL update at the acceptance edge, so a read accepted the next cycle returns the new value.
REQ-014 Writes SHALL produce no response.
REQ-015 A REG access with mem_addr_in[11:5] != 0 SHALL set error_out (sticky); such a write is ignored and such a read returns 0x00 with normal latency.
REQ-016 On timer_decr_in, DT and ST SHALL each decrement if nonzero and saturate at 0.
REQ-017 A processor write to DT or ST in the same cycle as timer_decr_in SHALL win.
REQ-018 active_audio_out SHALL be registered and equal (ST != 0).
REQ-019 mem_valid_out and disp_valid_out SHALL be mutually exclusive and routed by the port tag.
REQ-020 Data outputs SHALL hold their last value when the matching valid is low.

Reset
REQ-021 While rst_n_in is low: all registers 0x00 except PCh=0x02 and PCl=0x00 (PC=0x200).
REQ-022 While rst_n_in is low: pipeline flushed, all valid outputs 0, bram_we_out 0, error_out 0, active_audio_out 0, mem_ready_out follows REQ-006.
REQ-023 Reads in flight at reset SHALL be dropped and never returned.

Structure
REQ-024 chip8_pkg SHALL hold PROC_MEM_TYPE_REG, PROC_MEM_TYPE_RAM, PROC_MEM_TYPE_COUNT and the REG_* index constants (REG_IH=16 ... REG_ST=22).
REQ-025 Register file plus timers SHALL be one sub-module, chip8_regfile; the arbitration and latency pipeline SHALL stay in chip8_mem_ctrl.

Verification
REQ-026 Reset release -> back-to-back REG reads of 18 and 19 -> mem_valid_out on two consecutive cycles carrying 0x02 then 0x00, each 3 cycles after its accept.
REQ-027 RAM write 0x123<=0xAB, then a read of 0x123 the next cycle -> 0xAB returned 3 cycles after the read accept.
REQ-028 disp_valid_in held high while mem_valid_in is high -> mem_ready_out=0 and no processor accept; disp_valid_out fires 3 cycles after each display accept.
REQ-029 Write ST=0x02, then two timer_decr_in pulses -> active_audio_out falls the cycle after the second pulse; a write of DT=0x05 coinciding with a pulse leaves DT=0x05.
REQ-030 REG read of address 0x040 -> returns 0x00 and error_out goes and stays high.
REQ-031 rst_n_in asserted with 2 reads in flight -> no valid output pulse after reset release; PC reads back 0x200.

Source files
------------

// File: rtl/chip8_pkg.sv
// Shared constants and types for the CHIP-8 memory controller.
// Latency: none (package only).
// Backpressure: none (package only).
package chip8_pkg;

  // Processor request target: register file or BRAM-backed RAM
  localparam int PROC_MEM_TYPE_COUNT = 2;
  localparam int PROC_MEM_TYPE_W     = $clog2(PROC_MEM_TYPE_COUNT);
  localparam logic [PROC_MEM_TYPE_W-1:0] PROC_MEM_TYPE_REG = PROC_MEM_TYPE_W'(0);
  localparam logic [PROC_MEM_TYPE_W-1:0] PROC_MEM_TYPE_RAM = PROC_MEM_TYPE_W'(1);

  // Register file geometry and named slots (0-15 are V0-VF)
  localparam int REG_COUNT = 32;
  localparam int REG_AW    = 5;
  localparam int REG_IH    = 16;
  localparam int REG_IL    = 17;
  localparam int REG_PCH   = 18;
  localparam int REG_PCL   = 19;
  localparam int REG_SP    = 20;
  localparam int REG_DT    = 21;
  localparam int REG_ST    = 22;

  // Program counter comes out of reset at 0x200
  localparam logic [7:0] PCH_RST = 8'h02;
  localparam logic [7:0] PCL_RST = 8'h00;

  typedef enum logic {
    PORT_PROC = 1'b0,
    PORT_DISP = 1'b1
  } rd_port_e;

  // One slot of the read-return pipeline
  typedef struct packed {
    logic                       vld;
    rd_port_e                   port;
    logic [PROC_MEM_TYPE_W-1:0] mtype;
    logic [7:0]                 reg_dat;
  } rd_tag_t;

  // Timer decrement that sticks at zero
  function automatic logic [7:0] sat_dec(input logic [7:0] v);
    return (v == 8'h00) ? v : v - 8'd1;
  endfunction

endpackage

// File: rtl/chip8_regfile.sv
// CHIP-8 register file (V0-VF, I, PC, SP, DT, ST, spares) with 60 Hz timers.
// Latency: writes land at the clock edge; rd_dat is a combinational view of the array.
// Backpressure: none, every write is taken; a write to DT/ST beats a same-cycle timer tick.
// Ports: clk_in/rst_n_in clock and async active-low reset; wr_vld/wr_addr/wr_dat write port;
//        rd_addr/rd_dat read port; timer_decr 60 Hz strobe; audio_active registered (ST != 0).
module chip8_regfile
  import chip8_pkg::*;
(
  input  logic              clk_in,
  input  logic              rst_n_in,
  input  logic              wr_vld,
  input  logic [REG_AW-1:0] wr_addr,
  input  logic [7:0]        wr_dat,
  input  logic [REG_AW-1:0] rd_addr,
  output logic [7:0]        rd_dat,
  input  logic              timer_decr,
  output logic              audio_active
);

  logic [7:0] regs [REG_COUNT];
  logic [7:0] dt_nxt;
  logic [7:0] st_nxt;

  // Timer next values: tick first, then let a processor write override it
  always_comb begin
    dt_nxt = timer_decr ? sat_dec(regs[REG_DT]) : regs[REG_DT];
    st_nxt = timer_decr ? sat_dec(regs[REG_ST]) : regs[REG_ST];
    if (wr_vld && wr_addr == REG_AW'(REG_DT)) dt_nxt = wr_dat;
    if (wr_vld && wr_addr == REG_AW'(REG_ST)) st_nxt = wr_dat;
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < REG_COUNT; i++) regs[i] <= 8'h00;
      regs[REG_PCH] <= PCH_RST;
      regs[REG_PCL] <= PCL_RST;
      audio_active  <= 1'b0;
    end else begin
      if (wr_vld) regs[wr_addr] <= wr_dat;
      // DT/ST always take their merged next value, which already includes any write
      regs[REG_DT] <= dt_nxt;
      regs[REG_ST] <= st_nxt;
      // Tracks the new ST so the flag changes in the same cycle as the register
      audio_active <= (st_nxt != 8'h00);
    end
  end

  assign rd_dat = regs[rd_addr];

endmodule

// File: rtl/chip8_mem_ctrl.sv
// CHIP-8 memory controller: arbitrates processor and display onto one BRAM port plus a register file.
// Latency: every read returns exactly BRAM_LATENCY+1 cycles after acceptance, in order; writes return nothing.
// Backpressure: display has fixed priority and is always taken; mem_ready_out = !disp_valid_in.
// Ports: mem_* processor request/response; disp_* display read request/response; bram_* external BRAM
//        (bram_data_in valid BRAM_LATENCY cycles after bram_addr_out); active_audio_out ST != 0;
//        error_out sticky flag for register accesses outside 0-31.
module chip8_mem_ctrl
  import chip8_pkg::*;
#(
  parameter int BRAM_LATENCY = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       timer_decr_in,
  input  logic [11:0]                mem_addr_in,
  input  logic                       mem_we_in,
  input  logic                       mem_valid_in,
  input  logic [7:0]                 mem_data_in,
  input  logic [PROC_MEM_TYPE_W-1:0] mem_type_in,
  output logic                       mem_ready_out,
  output logic                       mem_valid_out,
  output logic [7:0]                 mem_data_out,
  input  logic                       disp_valid_in,
  input  logic [11:0]                disp_addr_in,
  output logic                       disp_valid_out,
  output logic [7:0]                 disp_data_out,
  output logic [11:0]                bram_addr_out,
  output logic                       bram_we_out,
  output logic [7:0]                 bram_data_out,
  input  logic [7:0]                 bram_data_in,
  output logic                       active_audio_out,
  output logic                       error_out
);

  localparam int RD_DEPTH = BRAM_LATENCY + 1;

  logic       proc_acc;
  logic       proc_reg;
  logic       proc_ram;
  logic       reg_bad;
  logic [7:0] rf_rd_dat;
  rd_tag_t    new_tag;
  rd_tag_t    pipe [RD_DEPTH];
  rd_tag_t    tail;
  logic [7:0] rsp_dat;

  // Display wins the single BRAM port outright
  assign mem_ready_out = ~disp_valid_in;
  assign proc_acc      = mem_valid_in & mem_ready_out;
  assign proc_reg      = proc_acc && (mem_type_in == PROC_MEM_TYPE_REG);
  assign proc_ram      = proc_acc && (mem_type_in == PROC_MEM_TYPE_RAM);
  // Register space is only 32 entries; any upper address bit is a bad access
  assign reg_bad       = |mem_addr_in[11:5];

  chip8_regfile u_regfile (
    .clk_in       (clk_in),
    .rst_n_in     (rst_n_in),
    .wr_vld       (proc_reg & mem_we_in & ~reg_bad),
    .wr_addr      (mem_addr_in[4:0]),
    .wr_dat       (mem_data_in),
    .rd_addr      (mem_addr_in[4:0]),
    .rd_dat       (rf_rd_dat),
    .timer_decr   (timer_decr_in),
    .audio_active (active_audio_out)
  );

  // Tag for a read accepted this cycle; register data is snapshotted now
  always_comb begin
    new_tag = '0;
    if (disp_valid_in) begin
      new_tag.vld   = 1'b1;
      new_tag.port  = PORT_DISP;
      new_tag.mtype = PROC_MEM_TYPE_RAM;
    end else if (proc_acc && !mem_we_in) begin
      new_tag.vld     = 1'b1;
      new_tag.port    = PORT_PROC;
      new_tag.mtype   = mem_type_in;
      new_tag.reg_dat = (proc_reg && !reg_bad) ? rf_rd_dat : 8'h00;
    end
  end

  assign tail    = pipe[RD_DEPTH-1];
  assign rsp_dat = (tail.mtype == PROC_MEM_TYPE_REG) ? tail.reg_dat : bram_data_in;

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int i = 0; i < RD_DEPTH; i++) pipe[i] <= '0;
      bram_addr_out  <= 12'h000;
      bram_we_out    <= 1'b0;
      bram_data_out  <= 8'h00;
      mem_valid_out  <= 1'b0;
      mem_data_out   <= 8'h00;
      disp_valid_out <= 1'b0;
      disp_data_out  <= 8'h00;
      error_out      <= 1'b0;
    end else begin
      // BRAM request register: one access per accepted RAM request
      bram_we_out <= 1'b0;
      if (disp_valid_in) begin
        bram_addr_out <= disp_addr_in;
      end else if (proc_ram) begin
        bram_addr_out <= mem_addr_in;
        bram_we_out   <= mem_we_in;
        if (mem_we_in) bram_data_out <= mem_data_in;
      end

      // Fixed-length shift keeps REG and RAM reads in acceptance order
      pipe[0] <= new_tag;
      for (int i = 1; i < RD_DEPTH; i++) pipe[i] <= pipe[i-1];

      mem_valid_out  <= tail.vld && (tail.port == PORT_PROC);
      disp_valid_out <= tail.vld && (tail.port == PORT_DISP);
      if (tail.vld && tail.port == PORT_PROC) mem_data_out  <= rsp_dat;
      if (tail.vld && tail.port == PORT_DISP) disp_data_out <= rsp_dat;

      if (proc_reg && reg_bad) error_out <= 1'b1;
    end
  end

endmodule
